player_datapath: RTL and testbench
==================================

Name: player_datapath

Overview:
- Datapath-side responder to the game control FSM.
- Consumes the one-hot command strobes init/idle/attack/up/down/left/right/draw and owns the player position and facing registers.
- On draw it erases the previous sprite footprint, then rasters the new sprite from an external sprite ROM into the VGA pixel-write port, and returns draw_done.
- Sits between the controller and the VGA adapter / sprite ROM.

Parameters:
SCREEN_W, 160, screen width in pixels
SCREEN_H, 120, screen height in pixels
SPRITE_W, 16, sprite width (power of 2)
SPRITE_H, 16, sprite height (power of 2)
STEP, 1, pixels moved per move command
START_X, 72, position loaded by reset/init
START_Y, 52, position loaded by reset/init
BG_COLOUR, 3'b000, erase colour
TRANSPARENT, 3'b101, ROM colour that is never plotted

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
init  in  1  load start position and facing
idle  in  1  no-op command (ignored)
attack  in  1  no-op command (reserved, ignored)
up  in  1  move up one STEP
down  in  1  move down one STEP
left  in  1  move left one STEP
right  in  1  move right one STEP
draw  in  1  request erase+redraw (level)
draw_done  out  1  one-cycle pulse: draw sequence complete
busy  out  1  high while erase/draw is in progress
rom_addr  out  10  {facing[1:0], py[3:0], px[3:0]}
rom_data  in  3  sprite colour, valid one cycle after rom_addr
vga_x  out  8  pixel x
vga_y  out  7  pixel y
vga_colour  out  3  pixel colour
vga_plot  out  1  pixel write enable

Behaviour:
- Reset (async, resetn=0): pos_x=prev_x=START_X, pos_y=prev_y=START_Y, facing=DOWN, state=S_IDLE, armed=1. Outputs: draw_done=0, busy=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, rom_addr=0.
- Facing encoding: UP=0, DOWN=1, LEFT=2, RIGHT=3.
- Commands are sampled only in S_IDLE. Priority: init > up > down > left > right > draw.
- init: pos=START, facing=DOWN. prev is unchanged.
- Moves update pos on the next edge and set facing to the commanded direction.
- Move clamping:
  - x range: 0..SCREEN_W-SPRITE_W.
  - y range: 0..SCREEN_H-SPRITE_H.
  - Saturate; never wrap. up at y=0 leaves y=0 but facing still becomes UP.
- Move commands held high move once per cycle.
- States: S_IDLE -> S_ERASE -> S_DRAW -> S_DONE -> S_IDLE.
- draw acceptance: only in S_IDLE with armed=1. Let the accepting edge be cycle 0. Then armed=0 and busy=1 from cycle 1.
- S_ERASE (cycles 1..SPRITE_W*SPRITE_H):
  - Raster px fastest, then py.
  - vga_plot=1, vga_x=prev_x+px, vga_y=prev_y+py, vga_colour=BG_COLOUR.
- S_DRAW:
  - rom_addr steps through the raster for pos/facing, starting one cycle before the first plot.
  - Plot cycles are 258..513 for 16x16; cycle 257 is a bubble for ROM latency.
  - Each plot cycle: vga_x=pos_x+px, vga_y=pos_y+py, vga_colour=rom_data.
  - vga_plot=1 only if rom_data != TRANSPARENT.
- S_DONE (cycle 514 for 16x16): draw_done=1 for exactly one cycle, busy=0, prev<=pos. Returns to S_IDLE.
- Re-arm: armed returns to 1 only after draw is sampled low. A held draw never triggers a second sequence.
- Commands arriving while busy are dropped, not queued.
- Mid-sequence reset aborts immediately with all outputs at reset values. No partial-plot recovery.
- Arithmetic: vga_x/vga_y sums never overflow given the clamp ranges. Counters are log2(SPRITE_W)/log2(SPRITE_H) bits and wrap naturally at the end of each row/frame.

Decomposition:
- Shared package game_pkg:
  - state enum (S_IDLE, S_ERASE, S_DRAW, S_DONE)
  - facing codes
  - BG_COLOUR / TRANSPARENT constants
  - SCREEN/SPRITE dimension constants
- One sub-module sprite_scan_counter: px/py raster counter with start/enable inputs and a last-pixel flag, instantiated once and reused for the erase and draw passes.

Test Plan:
- Reset, then draw held high 600 cycles -> 256 BG plots at (72..87, 52..67); first draw plot at cycle 258; exactly one draw_done at cycle 514; no second sequence while draw stays high.
- up pulse, then draw -> pos_y=51, rom_addr[9:8]=0. Erase covers y 52..67; draw covers y 51..66.
- 60 consecutive up cycles from y=52 -> pos_y saturates at 0, never wraps to 127. A further left pulse at x=0 keeps x=0 and sets facing=LEFT.
- ROM model returning TRANSPARENT for px<8 -> exactly 128 draw-pass plots, all with px>=8.
- right asserted at cycle 100 of a draw sequence -> pos unchanged afterwards; init and right asserted together in S_IDLE -> pos=(72,52), facing=DOWN.
- resetn low at cycle 300 of a sequence -> vga_plot=0 and busy=0 immediately; draw_done never pulses; pos=START.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants for the game datapath: screen/sprite geometry, colours,
// facing codes, draw-sequencer states and a saturating step helper.
package game_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned SPRITE_W = 16;
  localparam int unsigned SPRITE_H = 16;
  localparam int unsigned STEP     = 1;
  localparam int unsigned START_X  = 72;
  localparam int unsigned START_Y  = 52;

  localparam int unsigned MAX_X = SCREEN_W - SPRITE_W;
  localparam int unsigned MAX_Y = SCREEN_H - SPRITE_H;
  localparam int unsigned PX_W  = $clog2(SPRITE_W);
  localparam int unsigned PY_W  = $clog2(SPRITE_H);

  localparam logic [2:0] BG_COLOUR   = 3'b000;
  localparam logic [2:0] TRANSPARENT = 3'b101;

  localparam logic [1:0] FACE_UP    = 2'd0;
  localparam logic [1:0] FACE_DOWN  = 2'd1;
  localparam logic [1:0] FACE_LEFT  = 2'd2;
  localparam logic [1:0] FACE_RIGHT = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ERASE = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Move one STEP towards lim (inc=1) or towards 0 (inc=0), saturating at the end.
  function automatic logic [7:0] clamp_step(input logic [7:0] v, input logic inc,
                                            input logic [7:0] lim);
    if (inc) begin
      return (v > lim - 8'(STEP)) ? lim : v + 8'(STEP);
    end
    return (v < 8'(STEP)) ? 8'd0 : v - 8'(STEP);
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Raster counter over one sprite footprint: px fastest, then py; flags the last pixel.
module sprite_scan_counter
  import game_pkg::*;
(
  input  logic            clock,
  input  logic            resetn,
  input  logic            start,
  input  logic            enable,
  output logic [PX_W-1:0] px,
  output logic [PY_W-1:0] py,
  output logic            last
);

  logic [PX_W-1:0] px_q;
  logic [PY_W-1:0] py_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      px_q <= '0;
      py_q <= '0;
    end else if (start) begin
      px_q <= '0;
      py_q <= '0;
    end else if (enable) begin
      px_q <= px_q + 1'b1;
      if (px_q == '1) begin
        py_q <= py_q + 1'b1;
      end
    end
  end

  assign px   = px_q;
  assign py   = py_q;
  assign last = (px_q == '1) && (py_q == '1);

endmodule

// File: rtl/player_datapath.sv
// Player position/facing registers plus the erase-then-draw sprite sequencer
// that feeds the VGA pixel-write port from an external one-cycle-latency ROM.
module player_datapath
  import game_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       init,
  input  logic       idle,
  input  logic       attack,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       draw,
  output logic       draw_done,
  output logic       busy,
  output logic [9:0] rom_addr,
  input  logic [2:0] rom_data,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  logic [1:0] state_q, state_d;
  logic [7:0] pos_x_q, pos_x_d, prev_x_q, prev_x_d;
  logic [6:0] pos_y_q, pos_y_d, prev_y_q, prev_y_d;
  logic [1:0] facing_q, facing_d;
  logic       armed_q, armed_d;
  logic       fetch_done_q, fetch_done_d;
  logic       plot_vld_q;
  logic [PX_W-1:0] dpx_q;
  logic [PY_W-1:0] dpy_q;

  logic            scan_start, scan_enable, scan_last;
  logic [PX_W-1:0] scan_px;
  logic [PY_W-1:0] scan_py;

  logic unused_cmd;
  assign unused_cmd = idle | attack;

  sprite_scan_counter u_scan (
    .clock  (clock),
    .resetn (resetn),
    .start  (scan_start),
    .enable (scan_enable),
    .px     (scan_px),
    .py     (scan_py),
    .last   (scan_last)
  );

  // In S_DRAW the counter walks ROM addresses; fetch_done marks the extra cycle
  // that plots the final pixel after the last address has been issued.
  assign scan_enable = (state_q == S_ERASE) || ((state_q == S_DRAW) && !fetch_done_q);

  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    facing_d     = facing_q;
    armed_d      = armed_q | ~draw;
    fetch_done_d = fetch_done_q;
    scan_start   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        fetch_done_d = 1'b0;
        if (init) begin
          pos_x_d  = 8'(START_X);
          pos_y_d  = 7'(START_Y);
          facing_d = FACE_DOWN;
        end else if (up) begin
          pos_y_d  = 7'(clamp_step({1'b0, pos_y_q}, 1'b0, 8'(MAX_Y)));
          facing_d = FACE_UP;
        end else if (down) begin
          pos_y_d  = 7'(clamp_step({1'b0, pos_y_q}, 1'b1, 8'(MAX_Y)));
          facing_d = FACE_DOWN;
        end else if (left) begin
          pos_x_d  = clamp_step(pos_x_q, 1'b0, 8'(MAX_X));
          facing_d = FACE_LEFT;
        end else if (right) begin
          pos_x_d  = clamp_step(pos_x_q, 1'b1, 8'(MAX_X));
          facing_d = FACE_RIGHT;
        end else if (draw && armed_q) begin
          state_d    = S_ERASE;
          armed_d    = 1'b0;
          scan_start = 1'b1;
        end
      end
      S_ERASE: begin
        if (scan_last) begin
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        if (scan_last) begin
          fetch_done_d = 1'b1;
        end
        if (fetch_done_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        prev_x_d = pos_x_q;
        prev_y_d = pos_y_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      pos_x_q      <= 8'(START_X);
      pos_y_q      <= 7'(START_Y);
      prev_x_q     <= 8'(START_X);
      prev_y_q     <= 7'(START_Y);
      facing_q     <= FACE_DOWN;
      armed_q      <= 1'b1;
      fetch_done_q <= 1'b0;
      plot_vld_q   <= 1'b0;
      dpx_q        <= '0;
      dpy_q        <= '0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      facing_q     <= facing_d;
      armed_q      <= armed_d;
      fetch_done_q <= fetch_done_d;
      // Delay pixel coordinates to line up with rom_data
      plot_vld_q   <= (state_q == S_DRAW) && !fetch_done_q;
      dpx_q        <= scan_px;
      dpy_q        <= scan_py;
    end
  end

  always_comb begin
    vga_plot   = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    rom_addr   = '0;
    if (state_q == S_ERASE) begin
      vga_plot   = 1'b1;
      vga_x      = prev_x_q + 8'(scan_px);
      vga_y      = prev_y_q + 7'(scan_py);
      vga_colour = BG_COLOUR;
    end else if (state_q == S_DRAW) begin
      rom_addr = {facing_q, scan_py, scan_px};
      if (plot_vld_q) begin
        vga_x      = pos_x_q + 8'(dpx_q);
        vga_y      = pos_y_q + 7'(dpy_q);
        vga_colour = rom_data;
        vga_plot   = (rom_data != TRANSPARENT);
      end
    end
  end

  assign draw_done = (state_q == S_DONE);
  assign busy      = (state_q == S_ERASE) || (state_q == S_DRAW);

endmodule

// File: tb/tb_player_datapath.sv
// Directed bench for player_datapath: watches whole erase/draw sequences cycle by cycle.
module tb_player_datapath;

  logic       clock = 1'b0;
  logic       resetn;
  logic       init, idle, attack, up, down, left, right, draw;
  logic       draw_done, busy, vga_plot;
  logic [9:0] rom_addr;
  logic [2:0] rom_data;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       rom_mode;

  int total = 0;
  int bad   = 0;

  // Per-sequence observations and expectations
  int ex, ey, dx, dy;
  int erase_ok, draw_plots, draw_bad, first_plot, done_cnt, done_cyc, stray, busy_bad, rom_hi;

  always #5 clock = ~clock;

  // Sprite ROM: colour 3'b011, or TRANSPARENT for px<8 when rom_mode is set
  always @(posedge clock) begin
    rom_data <= (rom_mode && (rom_addr[3:0] < 4'd8)) ? 3'b101 : 3'b011;
  end

  player_datapath dut (
    .clock      (clock),
    .resetn     (resetn),
    .init       (init),
    .idle       (idle),
    .attack     (attack),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .draw       (draw),
    .draw_done  (draw_done),
    .busy       (busy),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mask = {init, up, down, left, right}, held for n sampling edges
  task automatic cmd(input logic [4:0] mask, input int n);
    @(negedge clock);
    {init, up, down, left, right} = mask;
    repeat (n) @(negedge clock);
    {init, up, down, left, right} = 5'b0;
  endtask

  // Raise draw, then observe cycles 1..ncyc after the accepting edge.
  // right is pulsed during cycle inj (0 = never).
  task automatic run_seq(input int ncyc, input int inj);
    erase_ok = 0; draw_plots = 0; draw_bad = 0; first_plot = 0;
    done_cnt = 0; done_cyc = 0; stray = 0; busy_bad = 0; rom_hi = -1;
    @(negedge clock);
    draw = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= ncyc; k++) begin
      int i;
      @(negedge clock);
      right = (k == inj);
      if (busy !== ((k >= 1) && (k <= 513))) busy_bad++;
      if (draw_done === 1'b1) begin
        done_cnt++;
        done_cyc = k;
      end
      if (k == 257) rom_hi = int'(rom_addr[9:8]);
      if (k >= 1 && k <= 256) begin
        i = k - 1;
        if (vga_plot === 1'b1 && vga_x == ex + i % 16 && vga_y == ey + i / 16 &&
            vga_colour == 3'b000) erase_ok++;
      end else if (k >= 258 && k <= 513) begin
        i = k - 258;
        if (vga_plot === 1'b1) begin
          draw_plots++;
          if (first_plot == 0) first_plot = k;
          if (vga_x != dx + i % 16 || vga_y != dy + i / 16 || vga_colour != 3'b011 ||
              (rom_mode && (i % 16 < 8))) draw_bad++;
        end
      end else if (vga_plot !== 1'b0) begin
        stray++;
      end
    end
    right = 1'b0;
    draw  = 1'b0;
  endtask

  task automatic check_seq(input string t, input int exp_plots, input int exp_first,
                           input int exp_face);
    check_val({t, " erase plots"}, erase_ok, 256);
    check_val({t, " draw plots"}, draw_plots, exp_plots);
    check_val({t, " draw pixel errors"}, draw_bad, 0);
    check_val({t, " first draw plot cycle"}, first_plot, exp_first);
    check_val({t, " draw_done count"}, done_cnt, 1);
    check_val({t, " draw_done cycle"}, done_cyc, 514);
    check_val({t, " stray plots"}, stray, 0);
    check_val({t, " busy errors"}, busy_bad, 0);
    check_val({t, " rom facing"}, rom_hi, exp_face);
  endtask

  initial begin
    int dn;
    resetn = 1'b0;
    {init, idle, attack, up, down, left, right, draw} = 8'b0;
    rom_mode = 1'b0;
    #12;
    check_val("reset busy", int'(busy), 0);
    check_val("reset plot", int'(vga_plot), 0);
    check_val("reset draw_done", int'(draw_done), 0);
    check_val("reset vga_x", int'(vga_x), 0);
    check_val("reset vga_y", int'(vga_y), 0);
    check_val("reset colour", int'(vga_colour), 0);
    check_val("reset rom_addr", int'(rom_addr), 0);
    @(negedge clock);
    resetn = 1'b1;

    // Held draw: one sequence only
    ex = 72; ey = 52; dx = 72; dy = 52;
    run_seq(600, 0);
    check_seq("t1", 256, 258, 1);

    // up pulse
    cmd(5'b01000, 1);
    ex = 72; ey = 52; dx = 72; dy = 51;
    run_seq(530, 0);
    check_seq("t2", 256, 258, 0);

    // Saturate at top-left corner, then re-face LEFT at x=0
    cmd(5'b01000, 60);
    cmd(5'b00010, 80);
    cmd(5'b01000, 1);
    cmd(5'b00010, 1);
    ex = 72; ey = 51; dx = 0; dy = 0;
    run_seq(530, 0);
    check_seq("t3", 256, 258, 2);

    // Transparent left half
    rom_mode = 1'b1;
    cmd(5'b00100, 3);
    ex = 0; ey = 0; dx = 0; dy = 3;
    run_seq(530, 0);
    check_seq("t4", 128, 266, 1);

    // Command while busy is dropped
    ex = 0; ey = 3; dx = 0; dy = 3;
    run_seq(530, 100);
    check_seq("t5a", 128, 266, 1);
    run_seq(530, 0);
    check_seq("t5b", 128, 266, 1);

    // init beats right
    cmd(5'b10001, 1);
    ex = 0; ey = 3; dx = 72; dy = 52;
    run_seq(530, 0);
    check_seq("t5c", 128, 266, 1);

    // Reset mid-sequence
    rom_mode = 1'b0;
    cmd(5'b00001, 2);
    @(negedge clock);
    draw = 1'b1;
    @(posedge clock);
    repeat (300) @(negedge clock);
    resetn = 1'b0;
    #1;
    check_val("abort plot", int'(vga_plot), 0);
    check_val("abort busy", int'(busy), 0);
    check_val("abort vga_x", int'(vga_x), 0);
    draw = 1'b0;
    dn = 0;
    repeat (2) begin
      @(negedge clock);
      if (draw_done !== 1'b0) dn++;
    end
    resetn = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (draw_done !== 1'b0 || busy !== 1'b0) dn++;
    end
    check_val("abort no done", dn, 0);
    ex = 72; ey = 52; dx = 72; dy = 52;
    run_seq(530, 0);
    check_seq("t6", 256, 258, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
